// File: rtl/mc_controller_pkg.sv
// Shared encodings, state enum and decoded-instruction payload for the multi-cycle MIPS controller.
package mc_controller_pkg;

  localparam int unsigned STATE_WIDTH = 3;
  localparam int unsigned OP_W        = 6;
  localparam int unsigned FLAG_W      = 32;
  localparam int unsigned SEL_W       = 2;
  localparam int unsigned ALUOP_W     = 3;

  localparam int unsigned FLAG_BIT_ZERO     = 0;
  localparam int unsigned FLAG_BIT_OVERFLOW = 1;

  typedef enum logic [STATE_WIDTH-1:0] {
    STATE_FETCH  = 3'd0,
    STATE_DECODE = 3'd1,
    STATE_EXEC   = 3'd2,
    STATE_MEM    = 3'd3,
    STATE_WB     = 3'd4
  } state_t;

  localparam logic [OP_W-1:0] OPCODE_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OPCODE_J     = 6'h02;
  localparam logic [OP_W-1:0] OPCODE_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OPCODE_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OPCODE_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OPCODE_ADDIU = 6'h09;
  localparam logic [OP_W-1:0] OPCODE_ORI   = 6'h0d;
  localparam logic [OP_W-1:0] OPCODE_LUI   = 6'h0f;
  localparam logic [OP_W-1:0] OPCODE_LW    = 6'h23;
  localparam logic [OP_W-1:0] OPCODE_SW    = 6'h2b;

  localparam logic [OP_W-1:0] FUNCT_JR   = 6'h08;
  localparam logic [OP_W-1:0] FUNCT_ADDU = 6'h21;
  localparam logic [OP_W-1:0] FUNCT_SUBU = 6'h23;
  localparam logic [OP_W-1:0] FUNCT_SLT  = 6'h2a;

  localparam logic [SEL_W-1:0] REGDST_RT  = 2'd0;
  localparam logic [SEL_W-1:0] REGDST_RD  = 2'd1;
  localparam logic [SEL_W-1:0] REGDST_RET = 2'd2;
  localparam logic [SEL_W-1:0] REGDST_ZZ  = 2'd3;

  localparam logic [SEL_W-1:0] MEM2REG_ALU = 2'd0;
  localparam logic [SEL_W-1:0] MEM2REG_RAM = 2'd1;
  localparam logic [SEL_W-1:0] MEM2REG_RET = 2'd2;
  localparam logic [SEL_W-1:0] MEM2REG_ZZ  = 2'd3;

  // All four selects are live, so the idle value aliases PC+4 (harmless while PCWr is low).
  localparam logic [SEL_W-1:0] NPC_SEL_PC_ADD_4 = 2'd0;
  localparam logic [SEL_W-1:0] NPC_SEL_BEQ_JMP  = 2'd1;
  localparam logic [SEL_W-1:0] NPC_SEL_J_JMP    = 2'd2;
  localparam logic [SEL_W-1:0] NPC_SEL_REG_JMP  = 2'd3;
  localparam logic [SEL_W-1:0] NPC_SEL_ZZ       = 2'd0;

  localparam logic [SEL_W-1:0] EXT_OP_ZERO = 2'd0;
  localparam logic [SEL_W-1:0] EXT_OP_SIGN = 2'd1;
  localparam logic [SEL_W-1:0] EXT_OP_HIGH = 2'd2;
  localparam logic [SEL_W-1:0] EXT_OP_ZZ   = 2'd3;

  localparam logic ALU_SRC_REG = 1'b0;
  localparam logic ALU_SRC_IMM = 1'b1;
  localparam logic ALU_SRC_ZZ  = 1'b0;

  localparam logic [ALUOP_W-1:0] ALU_OP_ADD  = 3'd0;
  localparam logic [ALUOP_W-1:0] ALU_OP_SUB  = 3'd1;
  localparam logic [ALUOP_W-1:0] ALU_OP_OR   = 3'd2;
  localparam logic [ALUOP_W-1:0] ALU_OP_LESS = 3'd3;
  localparam logic [ALUOP_W-1:0] ALU_OP_ZZ   = 3'd7;

  typedef struct packed {
    logic addu;
    logic subu;
    logic slt;
    logic jr;
    logic addiu;
    logic addi;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
  } instr_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct to one-hot class plus illegal flag.
module mc_decode
  import mc_controller_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  input  logic [OP_W-1:0] funct,
  output instr_t          cls_c,
  output logic            illegal_c
);

  always_comb begin
    cls_c = '0;
    case (opcode)
      OPCODE_RTYPE: begin
        case (funct)
          FUNCT_ADDU: cls_c.addu = 1'b1;
          FUNCT_SUBU: cls_c.subu = 1'b1;
          FUNCT_SLT:  cls_c.slt  = 1'b1;
          FUNCT_JR:   cls_c.jr   = 1'b1;
          default: ;
        endcase
      end
      OPCODE_J:     cls_c.j     = 1'b1;
      OPCODE_JAL:   cls_c.jal   = 1'b1;
      OPCODE_BEQ:   cls_c.beq   = 1'b1;
      OPCODE_ADDI:  cls_c.addi  = 1'b1;
      OPCODE_ADDIU: cls_c.addiu = 1'b1;
      OPCODE_ORI:   cls_c.ori   = 1'b1;
      OPCODE_LUI:   cls_c.lui   = 1'b1;
      OPCODE_LW:    cls_c.lw    = 1'b1;
      OPCODE_SW:    cls_c.sw    = 1'b1;
      default: ;
    endcase
    illegal_c = (cls_c == '0);
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS sequencer (FETCH/DECODE/EXEC/MEM/WB) driving the shared datapath control set.
// Optional MC_CTRL_MEM_WAIT_EN adds mem_rdy and stalls FETCH/MEM until the RAM is ready.
module mc_controller
  import mc_controller_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [OP_W-1:0]        opcode,
  input  logic [OP_W-1:0]        funct,
  input  logic [FLAG_W-1:0]      NFlag,
`ifdef MC_CTRL_MEM_WAIT_EN
  input  logic                   mem_rdy,
`endif
  output logic                   IRWr,
  output logic                   PCWr,
  output logic [SEL_W-1:0]       RegDst,
  output logic                   ALUSrc,
  output logic [SEL_W-1:0]       Mem2Reg,
  output logic                   RegWr,
  output logic                   MemWr,
  output logic [SEL_W-1:0]       NPCSel,
  output logic [SEL_W-1:0]       EXTOp,
  output logic [ALUOP_W-1:0]     ALUOp,
  output logic                   FlagOp,
  output logic                   illegal,
  output logic [STATE_WIDTH-1:0] state
);

  state_t state_q, state_d;
  instr_t cls;
  logic   dec_illegal;
  logic   rdy;
  logic   zero_flag, ovf_flag;
  logic   rtype_alu, imm_src;
  logic   unused_flags;

`ifdef MC_CTRL_MEM_WAIT_EN
  assign rdy = mem_rdy;
`else
  assign rdy = 1'b1;
`endif

  assign zero_flag    = NFlag[FLAG_BIT_ZERO];
  assign ovf_flag     = NFlag[FLAG_BIT_OVERFLOW];
  assign unused_flags = ^NFlag;
  assign rtype_alu    = cls.addu | cls.subu | cls.slt;
  assign imm_src      = cls.addiu | cls.addi | cls.ori | cls.lui | cls.lw | cls.sw;
  assign state        = state_q;

  mc_decode u_decode (
    .opcode    (opcode),
    .funct     (funct),
    .cls_c     (cls),
    .illegal_c (dec_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= STATE_FETCH;
    else        state_q <= state_d;
  end

  // Next state and Moore outputs; everything idles while reset is held.
  always_comb begin
    state_d = STATE_FETCH;
    IRWr    = 1'b0;
    PCWr    = 1'b0;
    RegDst  = REGDST_ZZ;
    ALUSrc  = ALU_SRC_ZZ;
    Mem2Reg = MEM2REG_ZZ;
    RegWr   = 1'b0;
    MemWr   = 1'b0;
    NPCSel  = NPC_SEL_ZZ;
    EXTOp   = EXT_OP_ZZ;
    ALUOp   = ALU_OP_ZZ;
    FlagOp  = 1'b0;
    illegal = 1'b0;
    if (rst_n) begin
      case (state_q)
        STATE_FETCH: begin
          IRWr    = 1'b1;
          state_d = rdy ? STATE_DECODE : STATE_FETCH;
        end
        STATE_DECODE: begin
          if (cls.j || cls.jal) begin
            PCWr   = 1'b1;
            NPCSel = NPC_SEL_J_JMP;
          end
          if (cls.jal) begin
            RegWr   = 1'b1;
            RegDst  = REGDST_RET;
            Mem2Reg = MEM2REG_RET;
          end
          if (cls.jr) begin
            PCWr   = 1'b1;
            NPCSel = NPC_SEL_REG_JMP;
          end
          if (dec_illegal) begin
            PCWr    = 1'b1;
            NPCSel  = NPC_SEL_PC_ADD_4;
            illegal = 1'b1;
          end
          if (!(cls.j || cls.jal || cls.jr || dec_illegal)) state_d = STATE_EXEC;
        end
        STATE_EXEC: begin
          ALUSrc = imm_src ? ALU_SRC_IMM : ALU_SRC_REG;
          if (cls.addiu || cls.addi || cls.lw || cls.sw || cls.beq) EXTOp = EXT_OP_SIGN;
          else if (cls.ori)                                        EXTOp = EXT_OP_ZERO;
          else if (cls.lui)                                        EXTOp = EXT_OP_HIGH;
          if (cls.subu || cls.beq)     ALUOp = ALU_OP_SUB;
          else if (cls.ori || cls.lui) ALUOp = ALU_OP_OR;
          else if (cls.slt)            ALUOp = ALU_OP_LESS;
          else                         ALUOp = ALU_OP_ADD;
          FlagOp = cls.addi;
          if (cls.beq) begin
            PCWr    = 1'b1;
            NPCSel  = zero_flag ? NPC_SEL_BEQ_JMP : NPC_SEL_PC_ADD_4;
            state_d = STATE_FETCH;
          end else if (cls.lw || cls.sw) begin
            state_d = STATE_MEM;
          end else begin
            state_d = STATE_WB;
          end
        end
        STATE_MEM: begin
          MemWr   = cls.sw;
          state_d = STATE_MEM;
          if (rdy) begin
            if (cls.sw) begin
              PCWr    = 1'b1;
              NPCSel  = NPC_SEL_PC_ADD_4;
              state_d = STATE_FETCH;
            end else begin
              state_d = STATE_WB;
            end
          end
        end
        STATE_WB: begin
          // Signed add that overflowed must leave the register file untouched.
          RegWr   = !(cls.addi && ovf_flag);
          RegDst  = rtype_alu ? REGDST_RD : REGDST_RT;
          Mem2Reg = cls.lw ? MEM2REG_RAM : MEM2REG_ALU;
          PCWr    = 1'b1;
          NPCSel  = NPC_SEL_PC_ADD_4;
          state_d = STATE_FETCH;
        end
        default: state_d = STATE_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: per-instruction expected control traces checked every cycle.
module tb_mc_controller;
  import mc_controller_pkg::*;

  typedef struct packed {
    logic [2:0] st;
    logic       irwr;
    logic       pcwr;
    logic [1:0] regdst;
    logic       alusrc;
    logic [1:0] mem2reg;
    logic       regwr;
    logic       memwr;
    logic [1:0] npcsel;
    logic [1:0] extop;
    logic [2:0] aluop;
    logic       flagop;
    logic       illegal;
  } ctl_t;

  typedef enum {K_ALU, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_JR, K_ILL} kind_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode, funct;
  logic [31:0] NFlag;
`ifdef MC_CTRL_MEM_WAIT_EN
  logic        mem_rdy;
`endif
  logic        IRWr, PCWr, ALUSrc, RegWr, MemWr, FlagOp, illegal;
  logic [1:0]  RegDst, Mem2Reg, NPCSel, EXTOp;
  logic [2:0]  ALUOp, state;

  ctl_t obs;
  ctl_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .opcode  (opcode),
    .funct   (funct),
    .NFlag   (NFlag),
`ifdef MC_CTRL_MEM_WAIT_EN
    .mem_rdy (mem_rdy),
`endif
    .IRWr    (IRWr),
    .PCWr    (PCWr),
    .RegDst  (RegDst),
    .ALUSrc  (ALUSrc),
    .Mem2Reg (Mem2Reg),
    .RegWr   (RegWr),
    .MemWr   (MemWr),
    .NPCSel  (NPCSel),
    .EXTOp   (EXTOp),
    .ALUOp   (ALUOp),
    .FlagOp  (FlagOp),
    .illegal (illegal),
    .state   (state)
  );

  assign obs = {state, IRWr, PCWr, RegDst, ALUSrc, Mem2Reg, RegWr, MemWr,
                NPCSel, EXTOp, ALUOp, FlagOp, illegal};

  function automatic ctl_t idle(input logic [2:0] st);
    ctl_t c;
    c         = '0;
    c.st      = st;
    c.regdst  = REGDST_ZZ;
    c.alusrc  = ALU_SRC_ZZ;
    c.mem2reg = MEM2REG_ZZ;
    c.npcsel  = NPC_SEL_ZZ;
    c.extop   = EXT_OP_ZZ;
    c.aluop   = ALU_OP_ZZ;
    return c;
  endfunction

  // Expected cycle-by-cycle control trace of one instruction, built from its class.
  function automatic void build(input logic [5:0] op, input logic [5:0] fn,
                                input logic zero, input logic ovf, input int waits);
    kind_t      k   = K_ILL;
    logic       src = 1'b0;
    logic [1:0] ext = EXT_OP_ZZ;
    logic [2:0] aop = ALU_OP_ZZ;
    ctl_t       c;
    case (op)
      6'h00: case (fn)
        6'h21: begin k = K_ALU; aop = ALU_OP_ADD;  end
        6'h23: begin k = K_ALU; aop = ALU_OP_SUB;  end
        6'h2a: begin k = K_ALU; aop = ALU_OP_LESS; end
        6'h08: k = K_JR;
        default: k = K_ILL;
      endcase
      6'h02: k = K_J;
      6'h03: k = K_JAL;
      6'h04: begin k = K_BEQ; ext = EXT_OP_SIGN; aop = ALU_OP_SUB; end
      6'h08, 6'h09: begin k = K_ALU; src = 1'b1; ext = EXT_OP_SIGN; aop = ALU_OP_ADD; end
      6'h0d: begin k = K_ALU; src = 1'b1; ext = EXT_OP_ZERO; aop = ALU_OP_OR; end
      6'h0f: begin k = K_ALU; src = 1'b1; ext = EXT_OP_HIGH; aop = ALU_OP_OR; end
      6'h23: begin k = K_LW; src = 1'b1; ext = EXT_OP_SIGN; aop = ALU_OP_ADD; end
      6'h2b: begin k = K_SW; src = 1'b1; ext = EXT_OP_SIGN; aop = ALU_OP_ADD; end
      default: k = K_ILL;
    endcase
    exp_q.delete();
    c = idle(3'd0); c.irwr = 1'b1; exp_q.push_back(c);
    c = idle(3'd1);
    if (k inside {K_J, K_JAL, K_JR, K_ILL}) begin
      c.pcwr = 1'b1;
      case (k)
        K_J:   c.npcsel = NPC_SEL_J_JMP;
        K_JAL: begin
          c.npcsel = NPC_SEL_J_JMP; c.regwr = 1'b1;
          c.regdst = REGDST_RET;    c.mem2reg = MEM2REG_RET;
        end
        K_JR:  c.npcsel = NPC_SEL_REG_JMP;
        default: begin c.npcsel = NPC_SEL_PC_ADD_4; c.illegal = 1'b1; end
      endcase
      exp_q.push_back(c);
      return;
    end
    exp_q.push_back(c);
    c = idle(3'd2);
    c.alusrc = src; c.extop = ext; c.aluop = aop; c.flagop = (op == 6'h08);
    if (k == K_BEQ) begin
      c.pcwr = 1'b1;
      c.npcsel = zero ? NPC_SEL_BEQ_JMP : NPC_SEL_PC_ADD_4;
      exp_q.push_back(c);
      return;
    end
    exp_q.push_back(c);
    if (k == K_LW || k == K_SW) begin
      for (int w = 0; w <= waits; w++) begin
        c = idle(3'd3);
        c.memwr = (k == K_SW);
        if (w == waits && k == K_SW) begin c.pcwr = 1'b1; c.npcsel = NPC_SEL_PC_ADD_4; end
        exp_q.push_back(c);
      end
      if (k == K_SW) return;
    end
    c = idle(3'd4);
    c.regwr   = !(op == 6'h08 && ovf);
    c.regdst  = (op == 6'h00) ? REGDST_RD : REGDST_RT;
    c.mem2reg = (k == K_LW) ? MEM2REG_RAM : MEM2REG_ALU;
    c.pcwr    = 1'b1;
    c.npcsel  = NPC_SEL_PC_ADD_4;
    exp_q.push_back(c);
  endfunction

  task automatic check(input string nm, input int idx, input ctl_t want);
    n_cmp++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s[%0d]: got %h want %h", nm, idx, obs, want);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  // Reset low until just after a rising edge, released so the next negedge sees FETCH.
  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    #1 check({nm, "_async"}, 0, idle(3'd0));
    @(negedge clk);
    #1 check({nm, "_hold"}, 1, idle(3'd0));
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic run(input string nm, input logic [5:0] op, input logic [5:0] fn,
                     input logic zero, input logic ovf, input int waits,
                     input int exp_len, input int abort_at);
    int pc_cnt  = 0;
    int mem_idx = 0;
    build(op, fn, zero, ovf, waits);
    check_int({nm, "_len"}, exp_q.size(), exp_len);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      if (i == 0) begin
        opcode = op;
        funct  = fn;
        NFlag  = 32'hA5A5_A5A0;
        NFlag[FLAG_BIT_ZERO]     = zero;
        NFlag[FLAG_BIT_OVERFLOW] = ovf;
      end
`ifdef MC_CTRL_MEM_WAIT_EN
      if (exp_q[i].st == 3'd3) begin
        mem_rdy = (mem_idx == waits);
        mem_idx++;
      end else begin
        mem_rdy = 1'b1;
      end
`else
      mem_idx = mem_idx + int'(exp_q[i].st == 3'd3);
`endif
      #1 check(nm, i, exp_q[i]);
      pc_cnt += int'(PCWr);
      if (i == abort_at) begin
        do_reset({nm, "_rst"});
        return;
      end
    end
    check_int({nm, "_pcwr_count"}, pc_cnt, 1);
  endtask

  initial begin
    rst_n  = 1'b0;
    opcode = 6'h00;
    funct  = 6'h00;
    NFlag  = '0;
`ifdef MC_CTRL_MEM_WAIT_EN
    mem_rdy = 1'b1;
`endif
    @(negedge clk);
    #1 check("reset", 0, idle(3'd0));
    @(posedge clk);
    #2 rst_n = 1'b1;

    run("addu",      6'h00, 6'h21, 1'b0, 1'b0, 0, 4, -1);
    run("lw",        6'h23, 6'h00, 1'b0, 1'b0, 0, 5, -1);
    run("sw",        6'h2b, 6'h00, 1'b0, 1'b0, 0, 4, -1);
    run("beq_taken", 6'h04, 6'h00, 1'b1, 1'b0, 0, 3, -1);
    run("beq_not",   6'h04, 6'h00, 1'b0, 1'b0, 0, 3, -1);
    run("jal",       6'h03, 6'h00, 1'b0, 1'b0, 0, 2, -1);
    run("jr",        6'h00, 6'h08, 1'b0, 1'b0, 0, 2, -1);
    run("j",         6'h02, 6'h00, 1'b0, 1'b0, 0, 2, -1);
    run("ill_op",    6'h3f, 6'h00, 1'b0, 1'b0, 0, 2, -1);
    run("ill_funct", 6'h00, 6'h3f, 1'b0, 1'b0, 0, 2, -1);
    run("addi_ovf",  6'h08, 6'h00, 1'b0, 1'b1, 0, 4, -1);
    run("addi_ok",   6'h08, 6'h12, 1'b1, 1'b0, 0, 4, -1);
    run("subu",      6'h00, 6'h23, 1'b0, 1'b0, 0, 4, -1);
    run("slt",       6'h00, 6'h2a, 1'b0, 1'b0, 0, 4, -1);
    run("addiu",     6'h09, 6'h00, 1'b0, 1'b1, 0, 4, -1);
    run("ori",       6'h0d, 6'h00, 1'b0, 1'b0, 0, 4, -1);
    run("lui",       6'h0f, 6'h00, 1'b0, 1'b0, 0, 4, -1);
    run("addi_abort", 6'h08, 6'h00, 1'b0, 1'b1, 0, 4, 2);
    run("after_rst", 6'h00, 6'h21, 1'b0, 1'b0, 0, 4, -1);
`ifdef MC_CTRL_MEM_WAIT_EN
    run("lw_wait",   6'h23, 6'h00, 1'b0, 1'b0, 3, 8, -1);
    run("sw_wait",   6'h2b, 6'h00, 1'b0, 1'b0, 2, 6, -1);
`endif
    run("tail_j",    6'h02, 6'h00, 1'b0, 1'b0, 0, 2, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
